// File: rtl/axi_prewrapper_frontend_if.sv
// ---------------------------------------------------------------------------
// axi_prewrapper_frontend_if
// AXI4-Lite slave channel bundle for the prewrapper front-end.
//   AW : s_axi_awaddr, s_axi_awvalid, s_axi_awready
//   W  : s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wready
//   B  : s_axi_bresp, s_axi_bvalid, s_axi_bready
//   AR : s_axi_araddr, s_axi_arvalid, s_axi_arready
//   R  : s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rready
// Modports: slave (the front-end), master (the interconnect / bench).
// ---------------------------------------------------------------------------
interface axi_prewrapper_frontend_if;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_prewrapper_frontend.sv
// ---------------------------------------------------------------------------
// axi_prewrapper_frontend
// AXI4-Lite slave front-end for axi_prewrapper_datapath. Converts AXI4-Lite
// handshakes into flat word-addressed strobes for the datapath and returns
// read data on R. Write and read paths are independent FSMs, one outstanding
// transaction each. All outputs are registered.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   s_axi        : AXI4-Lite slave channels (axi_prewrapper_frontend_if.slave)
//   axi_wr_addr  : word address of last issued write (held)
//   axi_wr_msg   : data of last issued write (held)
//   wr_strobe    : one-cycle write commit pulse
//   axi_rd_addr  : word address of last issued read (held)
//   rd_strobe    : one-cycle read issue pulse
//   axi_rd_msg   : read data from datapath, sampled RD_LATENCY cycles after rd_strobe
// ---------------------------------------------------------------------------
module axi_prewrapper_frontend #(
  parameter int ADDR_SHIFT = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  axi_prewrapper_frontend_if.slave        s_axi,
  output logic [31:0]                     axi_wr_addr,
  output logic [31:0]                     axi_wr_msg,
  output logic                            wr_strobe,
  output logic [31:0]                     axi_rd_addr,
  output logic                            rd_strobe,
  input  logic [31:0]                     axi_rd_msg
);

  localparam logic [2:0] LP_RD_LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // A write is rejected when its address is not word aligned or it is partial.
  function automatic logic wr_error(input logic [31:0] addr, input logic [3:0] strb);
    return (addr[1:0] != 2'b00) || (strb != 4'hF);
  endfunction

  // A read is rejected when its address is not word aligned.
  function automatic logic rd_error(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Write path registers
  wr_state_t   r_wr_state;
  logic        r_aw_got;
  logic        r_w_got;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wr_err;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_wr_strobe;
  logic [31:0] r_axi_wr_addr;
  logic [31:0] r_axi_wr_msg;

  // Read path registers
  rd_state_t   r_rd_state;
  logic [2:0]  r_rd_cnt;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic        r_rd_strobe;
  logic [31:0] r_axi_rd_addr;

  // Write-path combinational view of this cycle's handshakes
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_got_nxt;
  logic        w_w_got_nxt;
  logic [31:0] w_awaddr_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_wstrb_nxt;
  logic        w_wr_err;

  // Merge a handshake happening this cycle with what was captured earlier so
  // the issue decision can be made on the same edge as the final handshake.
  always_comb begin
    w_aw_hs      = s_axi.s_axi_awvalid & r_awready;
    w_w_hs       = s_axi.s_axi_wvalid & r_wready;
    w_aw_got_nxt = r_aw_got | w_aw_hs;
    w_w_got_nxt  = r_w_got | w_w_hs;
    w_awaddr_nxt = w_aw_hs ? s_axi.s_axi_awaddr : r_awaddr;
    w_wdata_nxt  = w_w_hs ? s_axi.s_axi_wdata : r_wdata;
    w_wstrb_nxt  = w_w_hs ? s_axi.s_axi_wstrb : r_wstrb;
    w_wr_err     = wr_error(w_awaddr_nxt, w_wstrb_nxt);
  end

  // Write FSM: capture AW/W in any order, issue one strobe, then hold B until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_state    <= W_IDLE;
      r_aw_got      <= 1'b0;
      r_w_got       <= 1'b0;
      r_awaddr      <= 32'd0;
      r_wdata       <= 32'd0;
      r_wstrb       <= 4'd0;
      r_wr_err      <= 1'b0;
      r_awready     <= 1'b0;
      r_wready      <= 1'b0;
      r_bvalid      <= 1'b0;
      r_bresp       <= 2'b00;
      r_wr_strobe   <= 1'b0;
      r_axi_wr_addr <= 32'd0;
      r_axi_wr_msg  <= 32'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr <= s_axi.s_axi_awaddr;
          end else begin
            r_awaddr <= r_awaddr;
          end
          if (w_w_hs) begin
            r_wdata <= s_axi.s_axi_wdata;
            r_wstrb <= s_axi.s_axi_wstrb;
          end else begin
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
          end
          r_aw_got <= w_aw_got_nxt;
          r_w_got  <= w_w_got_nxt;
          if (w_aw_got_nxt && w_w_got_nxt) begin
            // The strobe is visible during the single W_ISSUE cycle.
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_wr_err   <= w_wr_err;
            r_wr_state <= W_ISSUE;
            if (!w_wr_err) begin
              r_wr_strobe   <= 1'b1;
              r_axi_wr_addr <= w_awaddr_nxt >> ADDR_SHIFT;
              r_axi_wr_msg  <= w_wdata_nxt;
            end else begin
              r_wr_strobe <= 1'b0;
            end
          end else begin
            r_awready <= !w_aw_got_nxt;
            r_wready  <= !w_w_got_nxt;
          end
        end
        W_ISSUE: begin
          r_bvalid   <= 1'b1;
          r_bresp    <= r_wr_err ? 2'b10 : 2'b00;
          r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.s_axi_bready) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end else begin
            r_wr_state <= W_RESP;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_aw_got   <= 1'b0;
          r_w_got    <= 1'b0;
          r_awready  <= 1'b0;
          r_wready   <= 1'b0;
          r_bvalid   <= 1'b0;
          r_bresp    <= 2'b00;
        end
      endcase
    end
  end

  // Read FSM: accept AR, pulse rd_strobe, wait RD_LATENCY cycles, hold R until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state    <= R_IDLE;
      r_rd_cnt      <= 3'd0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rresp       <= 2'b00;
      r_rdata       <= 32'd0;
      r_rd_strobe   <= 1'b0;
      r_axi_rd_addr <= 32'd0;
    end else begin
      r_rd_strobe <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (s_axi.s_axi_arvalid && r_arready) begin
            r_arready <= 1'b0;
            if (rd_error(s_axi.s_axi_araddr)) begin
              // Unaligned reads never reach the datapath.
              r_rvalid   <= 1'b1;
              r_rdata    <= 32'd0;
              r_rresp    <= 2'b10;
              r_rd_state <= R_RESP;
            end else begin
              r_rd_strobe   <= 1'b1;
              r_axi_rd_addr <= s_axi.s_axi_araddr >> ADDR_SHIFT;
              r_rd_cnt      <= 3'd0;
              r_rd_state    <= R_WAIT;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          // r_rd_cnt is 0 in the strobe cycle; sample once it reaches the latency.
          if (r_rd_cnt == LP_RD_LAT) begin
            r_rdata    <= axi_rd_msg;
            r_rresp    <= 2'b00;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
          end
        end
        R_RESP: begin
          if (s_axi.s_axi_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end else begin
            r_rd_state <= R_RESP;
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
          r_arready  <= 1'b0;
          r_rvalid   <= 1'b0;
          r_rresp    <= 2'b00;
          r_rd_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign s_axi.s_axi_awready = r_awready;
  assign s_axi.s_axi_wready  = r_wready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign wr_strobe           = r_wr_strobe;
  assign axi_wr_addr         = r_axi_wr_addr;
  assign axi_wr_msg          = r_axi_wr_msg;
  assign rd_strobe           = r_rd_strobe;
  assign axi_rd_addr         = r_axi_rd_addr;

endmodule

// File: tb/tb_axi_prewrapper_frontend.sv
// ---------------------------------------------------------------------------
// tb_axi_prewrapper_frontend
// Scoreboard bench: stimulus tasks push expected strobes/responses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// The datapath is modelled as a word-indexed function whose data is only
// offered in the cycle RD_LATENCY after rd_strobe.
// ---------------------------------------------------------------------------
module tb_axi_prewrapper_frontend;
  localparam int RD_LAT = 1;
  localparam int TMO    = 200;

  logic        clk;
  logic        reset;
  logic [31:0] axi_wr_addr;
  logic [31:0] axi_wr_msg;
  logic        wr_strobe;
  logic [31:0] axi_rd_addr;
  logic        rd_strobe;
  logic [31:0] axi_rd_msg;

  axi_prewrapper_frontend_if bus();

  axi_prewrapper_frontend #(.ADDR_SHIFT(2), .RD_LATENCY(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axi       (bus),
    .axi_wr_addr (axi_wr_addr),
    .axi_wr_msg  (axi_wr_msg),
    .wr_strobe   (wr_strobe),
    .axi_rd_addr (axi_rd_addr),
    .rd_strobe   (rd_strobe),
    .axi_rd_msg  (axi_rd_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_wr_cyc = -1;
  int last_rd_cyc = -2;

  logic [31:0] exp_wr_addr_q[$];
  logic [31:0] exp_wr_msg_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_rd_addr_q[$];
  logic [31:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];

  // Datapath contents: arbitrary but deterministic per word, plus one fixed word.
  function automatic logic [31:0] dp_data(input logic [31:0] w);
    if (w == 32'h20) return 32'h12345678;
    return (w * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  // Datapath timing model: real data only exactly RD_LAT cycles after rd_strobe.
  logic [7:0] lat_cnt;
  logic [7:0] lat;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_strobe) lat_cnt <= 8'd1;
    else if (lat_cnt != 8'd255) lat_cnt <= lat_cnt + 8'd1;
  end
  always_comb begin
    lat = rd_strobe ? 8'd0 : lat_cnt;
    axi_rd_msg = (lat == 8'(RD_LAT)) ? dp_data(axi_rd_addr) : (32'hBAD00000 | {24'd0, lat});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  function automatic logic any_output();
    return |{bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_bresp,
             bus.s_axi_arready, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata,
             wr_strobe, rd_strobe, axi_wr_addr, axi_wr_msg, axi_rd_addr};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic err;
    int k;
    err = (addr[1:0] != 2'b00) || (strb != 4'hF);
    if (!err) begin
      exp_wr_addr_q.push_back(addr >> 2);
      exp_wr_msg_q.push_back(data);
    end
    exp_b_q.push_back(err ? 2'b10 : 2'b00);
    fork
      begin
        int ka;
        repeat (aw_dly) @(posedge clk);
        #1;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awvalid = 1'b1;
        ka = 0;
        @(negedge clk);
        while (!bus.s_axi_awready && ka < TMO) begin @(negedge clk); ka++; end
        if (!bus.s_axi_awready) timeout("aw_handshake");
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
      end
      begin
        int kw;
        repeat (w_dly) @(posedge clk);
        #1;
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_wvalid = 1'b1;
        kw = 0;
        @(negedge clk);
        while (!bus.s_axi_wready && kw < TMO) begin @(negedge clk); kw++; end
        if (!bus.s_axi_wready) timeout("w_handshake");
        @(posedge clk); #1;
        bus.s_axi_wvalid = 1'b0;
      end
    join
    repeat (b_dly) @(posedge clk);
    #1 bus.s_axi_bready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.s_axi_bvalid && k < TMO) begin @(negedge clk); k++; end
    if (!bus.s_axi_bvalid) timeout("b_handshake");
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int k;
    if (addr[1:0] != 2'b00) begin
      exp_rdata_q.push_back(32'd0);
      exp_rresp_q.push_back(2'b10);
    end else begin
      exp_rd_addr_q.push_back(addr >> 2);
      exp_rdata_q.push_back(dp_data(addr >> 2));
      exp_rresp_q.push_back(2'b00);
    end
    repeat (ar_dly) @(posedge clk);
    #1;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.s_axi_arready && k < TMO) begin @(negedge clk); k++; end
    if (!bus.s_axi_arready) timeout("ar_handshake");
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    repeat (r_dly) @(posedge clk);
    #1 bus.s_axi_rready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.s_axi_rvalid && k < TMO) begin @(negedge clk); k++; end
    if (!bus.s_axi_rvalid) timeout("r_handshake");
    @(posedge clk); #1;
    bus.s_axi_rready = 1'b0;
  endtask

  // Monitor: compare every strobe/response against the scoreboard queues.
  initial begin
    logic        p_bvalid, p_bready, p_rvalid, p_rready;
    logic [1:0]  p_bresp, p_rresp;
    logic [31:0] p_rdata;
    p_bvalid = 1'b0; p_bready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
    p_bresp = 2'b00; p_rresp = 2'b00; p_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wr_strobe) begin
          last_wr_cyc = cyc;
          if (exp_wr_addr_q.size() == 0) timeout("unexpected_wr_strobe");
          else begin
            check("wr_addr", 64'(axi_wr_addr), 64'(exp_wr_addr_q.pop_front()));
            check("wr_msg", 64'(axi_wr_msg), 64'(exp_wr_msg_q.pop_front()));
          end
        end
        if (bus.s_axi_bvalid && bus.s_axi_bready) begin
          if (exp_b_q.size() == 0) timeout("unexpected_b");
          else check("bresp", 64'(bus.s_axi_bresp), 64'(exp_b_q.pop_front()));
        end
        if (rd_strobe) begin
          last_rd_cyc = cyc;
          if (exp_rd_addr_q.size() == 0) timeout("unexpected_rd_strobe");
          else check("rd_addr", 64'(axi_rd_addr), 64'(exp_rd_addr_q.pop_front()));
        end
        if (bus.s_axi_rvalid && bus.s_axi_rready) begin
          if (exp_rdata_q.size() == 0) timeout("unexpected_r");
          else begin
            check("rdata", 64'(bus.s_axi_rdata), 64'(exp_rdata_q.pop_front()));
            check("rresp", 64'(bus.s_axi_rresp), 64'(exp_rresp_q.pop_front()));
          end
        end
        if (p_bvalid && !p_bready)
          check("b_hold", 64'({bus.s_axi_bvalid, bus.s_axi_bresp}), 64'({1'b1, p_bresp}));
        if (p_rvalid && !p_rready)
          check("r_hold", 64'({bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata}),
                64'({1'b1, p_rresp, p_rdata}));
        if (bus.s_axi_bvalid)
          check("aw_w_blocked_in_resp", 64'({bus.s_axi_awready, bus.s_axi_wready}), 64'd0);
        if (bus.s_axi_rvalid)
          check("ar_blocked_in_resp", 64'(bus.s_axi_arready), 64'd0);
        p_bvalid = bus.s_axi_bvalid; p_bready = bus.s_axi_bready; p_bresp = bus.s_axi_bresp;
        p_rvalid = bus.s_axi_rvalid; p_rready = bus.s_axi_rready;
        p_rresp  = bus.s_axi_rresp;  p_rdata  = bus.s_axi_rdata;
      end else begin
        p_bvalid = 1'b0; p_rvalid = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.s_axi_awaddr = 32'd0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = 32'd0;  bus.s_axi_wstrb = 4'd0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = 32'd0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    lat_cnt = 8'd255;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero", 64'(any_output()), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("readies_after_release", 64'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 64'h7);

    // Directed writes
    do_write(32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_write(32'h100, 32'hCAFEF00D, 4'hF, 3, 0, 5);
    do_write(32'h42, 32'h11111111, 4'hF, 0, 0, 1);
    do_write(32'h44, 32'h22222222, 4'h3, 0, 1, 0);

    // Directed reads
    do_read(32'h80, 0, 4);
    do_read(32'h81, 1, 2);

    // Simultaneous write and read
    fork
      do_write(32'h04, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      do_read(32'h84, 0, 0);
    join
    check("strobes_same_cycle", 64'(last_wr_cyc), 64'(last_rd_cyc));

    // Randomized traffic on both paths in parallel
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [31:0] a;
          logic [3:0]  s;
          a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
          s = 4'hF;
          if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 14));
          do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          logic [31:0] a;
          a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
          do_read(a, $urandom_range(0, 3), $urandom_range(0, 4));
        end
      end
    join

    // Reset one cycle before the write would issue
    @(posedge clk); #1;
    bus.s_axi_awaddr = 32'h8; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = 32'h5555AAAA; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    #1 check("reset_in_write_outputs_zero", 64'(any_output()), 64'd0);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("readies_after_write_reset", 64'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 64'h7);

    // Reset while the read waits for datapath data
    exp_rd_addr_q.push_back(32'h20);
    bus.s_axi_araddr = 32'h80; bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1 check("reset_in_read_outputs_zero", 64'(any_output()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("readies_after_read_reset", 64'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 64'h7);
    repeat (10) @(negedge clk);
    check("no_response_after_reset", 64'({bus.s_axi_bvalid, bus.s_axi_rvalid}), 64'd0);

    check("scoreboard_drained", 64'(exp_wr_addr_q.size() + exp_b_q.size() + exp_rd_addr_q.size()
                                     + exp_rdata_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
